// File: rtl/systolic_pkg.sv
// Shared defaults, state encoding and tile select codes for the systolic array feeder.
package systolic_pkg;

    localparam int unsigned N        = 8;
    localparam int unsigned DIM      = 4;
    localparam int unsigned FEED_LEN = 3 * DIM - 2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_e;

endpackage

// File: rtl/tile_buffer.sv
// DIM x DIM x N register file with a row write port and all elements visible in parallel.
// Element (r,c) appears at data[(r*DIM+c)*N +: N].
module tile_buffer #(
    parameter int unsigned N      = systolic_pkg::N,
    parameter int unsigned DIM    = systolic_pkg::DIM,
    localparam int unsigned RW    = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [RW-1:0]         wr_row,
    input  logic [DIM*N-1:0]      wr_data,
    output logic [DIM*DIM*N-1:0]  data
);

    logic [DIM-1:0][DIM*N-1:0] rows_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q <= '0;
        end else if (wr_en) begin
            rows_q[wr_row] <= wr_data;
        end
    end

    assign data = rows_q;

endmodule

// File: rtl/systolic_feeder.sv
// Buffers A/B tiles, feeds them skewed into a DIM x DIM systolic array and drains C.
// Define FEEDER_AUTOCLEAR_EN to prepend a DIM-cycle accumulator CLEAR phase to every run.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned N      = systolic_pkg::N,
    parameter int unsigned DIM    = systolic_pkg::DIM,
    localparam int unsigned RW    = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [RW-1:0]     ld_row,
    input  logic [DIM*N-1:0]  ld_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DIM*N-1:0]  a_edge,
    output logic [DIM*N-1:0]  b_edge,
    output logic [DIM*N-1:0]  c_edge,
    output logic              out_sign
);

    localparam int unsigned FEED_CYCLES = 3 * DIM - 2;
    localparam int unsigned CW          = $clog2(FEED_CYCLES + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                ld_fire;
    logic [DIM*DIM*N-1:0] a_tile, b_tile;

    assign ld_ready = (state_q == IDLE) && !start;
    assign ld_fire  = ld_valid && ld_ready;

    tile_buffer #(.N(N), .DIM(DIM)) u_a_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ld_fire && (ld_sel == SEL_A)),
        .wr_row  (ld_row),
        .wr_data (ld_data),
        .data    (a_tile)
    );

    tile_buffer #(.N(N), .DIM(DIM)) u_b_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ld_fire && (ld_sel == SEL_B)),
        .wr_row  (ld_row),
        .wr_data (ld_data),
        .data    (b_tile)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
`ifdef FEEDER_AUTOCLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = FEED;
`endif
                    cnt_d = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == CW'(DIM - 1)) begin
                    state_d = FEED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FEED: begin
                if (cnt_q == CW'(FEED_CYCLES - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(DIM - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane i carries A[i][k] and B[k][i] at feed step t = i + k.
    always_comb begin
        a_edge = '0;
        b_edge = '0;
        if (state_q == FEED) begin
            for (int i = 0; i < DIM; i++) begin
                for (int k = 0; k < DIM; k++) begin
                    if (int'(cnt_q) == i + k) begin
                        a_edge[i*N +: N] = a_tile[(i*DIM + k)*N +: N];
                        b_edge[i*N +: N] = b_tile[(k*DIM + i)*N +: N];
                    end
                end
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign out_sign = (state_q == CLEAR) || (state_q == DRAIN);
    assign c_edge   = '0;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural PE-array model fed from the DUT edges.
`timescale 1ns/1ps
module tb_systolic_feeder;
    import systolic_pkg::*;

`ifdef FEEDER_AUTOCLEAR_EN
    localparam int CLR_LEN = DIM;
`else
    localparam int CLR_LEN = 0;
`endif
    localparam int RUN_LEN = CLR_LEN + FEED_LEN + DIM;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     ld_valid = 1'b0;
    logic                     ld_ready;
    logic                     ld_sel = 1'b0;
    logic [$clog2(DIM)-1:0]   ld_row = '0;
    logic [DIM*N-1:0]         ld_data = '0;
    logic                     start = 1'b0;
    logic                     busy, done, out_sign;
    logic [DIM*N-1:0]         a_edge, b_edge, c_edge;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] mat_a [DIM][DIM];
    logic [N-1:0] mat_b [DIM][DIM];
    logic [N-1:0] cap   [DIM][DIM];
    logic [N-1:0] pa    [DIM][DIM];
    logic [N-1:0] pb    [DIM][DIM];
    logic [N-1:0] pc    [DIM][DIM];
    int           drain_idx = 0;
    bit           fed = 0;

    always #5 clk = ~clk;

    systolic_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_sel   (ld_sel),
        .ld_row   (ld_row),
        .ld_data  (ld_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .a_edge   (a_edge),
        .b_edge   (b_edge),
        .c_edge   (c_edge),
        .out_sign (out_sign)
    );

    function automatic logic [N-1:0] a_in(int i, int j);
        if (j == 0) return a_edge[i*N +: N];
        return pa[i][j-1];
    endfunction

    function automatic logic [N-1:0] b_in(int i, int j);
        if (i == 0) return b_edge[j*N +: N];
        return pb[i-1][j];
    endfunction

    function automatic logic [N-1:0] c_in(int i, int j);
        if (i == 0) return c_edge[j*N +: N];
        return pc[i-1][j];
    endfunction

    // PE array model: a moves right, b moves down, c accumulates or shifts down.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    pa[i][j] <= '0; pb[i][j] <= '0; pc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    pa[i][j] <= a_in(i, j);
                    pb[i][j] <= b_in(i, j);
                    pc[i][j] <= out_sign ? c_in(i, j) : pc[i][j] + a_in(i, j) * b_in(i, j);
                end
        end
    end

    always @(negedge clk) begin
        if (!busy) begin
            fed = 0;
            drain_idx = 0;
        end else if (!out_sign) begin
            fed = 1;
        end else if (fed && drain_idx < DIM) begin
            for (int j = 0; j < DIM; j++) cap[DIM-1-drain_idx][j] = pc[DIM-1][j];
            drain_idx++;
        end
    end

    task automatic clear_cap();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) cap[r][c] = 'x;
    endtask

    task automatic load_tiles(input bit do_a, input bit do_b);
        for (int s = 0; s < 2; s++) begin
            if ((s == 0 && do_a) || (s == 1 && do_b)) begin
                for (int r = 0; r < DIM; r++) begin
                    ld_valid = 1'b1;
                    ld_sel   = (s == 0) ? SEL_A : SEL_B;
                    ld_row   = r[$clog2(DIM)-1:0];
                    for (int k = 0; k < DIM; k++)
                        ld_data[k*N +: N] = (s == 0) ? mat_a[r][k] : mat_b[r][k];
                    @(negedge clk);
                end
            end
        end
        ld_valid = 1'b0;
    endtask

    task automatic fill(input int a_val, input int b_val);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                mat_a[r][c] = N'(a_val);
                mat_b[r][c] = N'(b_val);
            end
    endtask

    task automatic set_identity_a();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) mat_a[r][c] = (r == c) ? N'(1) : N'(0);
    endtask

    // Runs one tile product; noisy mode pokes start and load beats while busy.
    task automatic run(input bit noisy, output int n, output bit got_done,
                       output bit rdy_start, output bit rdy_busy, output bit busy_at_done);
        clear_cap();
        start = 1'b1;
        if (noisy) begin
            ld_valid = 1'b1; ld_sel = SEL_B; ld_row = 1; ld_data = {DIM{8'hAA}};
        end
        #1 rdy_start = ld_ready;
        @(negedge clk);
        start = 1'b0; ld_valid = 1'b0;
        n = 0; got_done = 0; rdy_busy = 0; busy_at_done = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                got_done = 1; busy_at_done = busy;
                break;
            end
            if (busy) begin
                n++;
                if (ld_ready) rdy_busy = 1;
                if (noisy) begin
                    start = (c % 3 == 0);
                    ld_valid = 1'b1; ld_sel = SEL_A; ld_row = 0; ld_data = {DIM{8'h55}};
                end
            end
            @(negedge clk);
            start = 1'b0; ld_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
            checks++; if (out_sign !== 1'b0) begin errors++; $display("FAIL reset_out_sign: got %b want 0", out_sign); end
            checks++; if ({a_edge, b_edge, c_edge} !== '0) begin errors++; $display("FAIL reset_edges: got %h/%h/%h want 0", a_edge, b_edge, c_edge); end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_feed();
        int n; bit gd, rs, rb, bd;
        fill(1, 1);
        load_tiles(1, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (CLR_LEN + 2) @(negedge clk);
        checks++; if (a_edge !== 32'h00010101) begin errors++; $display("FAIL midfeed_a_t2: got %h want 00010101", a_edge); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || out_sign !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b os=%b want 0 0", busy, out_sign); end
        checks++; if ({a_edge, b_edge} !== '0) begin errors++; $display("FAIL midreset_edges: got %h %h want 0", a_edge, b_edge); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL midreset_ld_ready: got %b want 1", ld_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got %b want 0", done); end
        // Buffers were cleared, so an unloaded run yields zeros.
        run(0, n, gd, rs, rb, bd);
        checks++; if (!gd || n != RUN_LEN) begin errors++; $display("FAIL midreset_run_len: got %0d done=%b want %0d", n, gd, RUN_LEN); end
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                checks++; if (cap[r][c] !== 8'd0) begin errors++; $display("FAIL midreset_c[%0d][%0d]: got %0d want 0", r, c, cap[r][c]); end
            end
    endtask

    task automatic test_identity();
        int n; bit gd, rs, rb, bd;
        set_identity_a();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) mat_b[r][c] = N'(4*r + c + 1);
        load_tiles(1, 1);
        run(0, n, gd, rs, rb, bd);
        checks++; if (!gd || n != RUN_LEN) begin errors++; $display("FAIL ident_run_len: got %0d done=%b want %0d", n, gd, RUN_LEN); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL ident_busy_at_done: got %b want 0", bd); end
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                checks++; if (cap[r][c] !== N'(4*r + c + 1)) begin errors++; $display("FAIL ident_c[%0d][%0d]: got %0d want %0d", r, c, cap[r][c], 4*r + c + 1); end
            end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ident_done_pulse: got %b want 0", done); end
    endtask

    // A = 2I + superdiagonal, B kept from the previous load: C[i][j] = 2B[i][j] + B[i+1][j].
    task automatic test_general();
        int n; bit gd, rs, rb, bd;
        int exp;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) mat_a[r][c] = (c == r) ? 8'd2 : ((c == r + 1) ? 8'd1 : 8'd0);
        load_tiles(1, 0);
        run(0, n, gd, rs, rb, bd);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                exp = (r < DIM - 1) ? 12*r + 3*c + 7 : 26 + 2*c;
                checks++; if (cap[r][c] !== N'(exp)) begin errors++; $display("FAIL general_c[%0d][%0d]: got %0d want %0d", r, c, cap[r][c], exp); end
            end
    endtask

    task automatic test_skew();
        logic [DIM*N-1:0] exp;
        bit gd;
        fill(1, 1);
        load_tiles(1, 1);
        clear_cap();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (CLR_LEN) @(negedge clk);
        for (int t = 0; t < int'(FEED_LEN); t++) begin
            exp = '0;
            for (int i = 0; i < DIM; i++) if (t >= i && t - i < DIM) exp[i*N +: N] = 8'd1;
            checks++; if (a_edge !== exp || out_sign !== 1'b0) begin errors++; $display("FAIL skew_a_t%0d: got %h os=%b want %h os=0", t, a_edge, out_sign, exp); end
            checks++; if (b_edge !== exp) begin errors++; $display("FAIL skew_b_t%0d: got %h want %h", t, b_edge, exp); end
            @(negedge clk);
        end
        gd = 0;
        for (int c = 0; c < 50 && !gd; c++) begin
            if (done) gd = 1; else @(negedge clk);
        end
        checks++; if (!gd) begin errors++; $display("FAIL skew_done: got 0 want 1"); end
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                checks++; if (cap[r][c] !== 8'd4) begin errors++; $display("FAIL skew_c[%0d][%0d]: got %0d want 4", r, c, cap[r][c]); end
            end
    endtask

    task automatic test_wrap();
        int n; bit gd, rs, rb, bd;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) fill(16, 16); else fill(3, 3);
            load_tiles(1, 1);
            run(0, n, gd, rs, rb, bd);
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    checks++; if (cap[r][c] !== ((p == 0) ? 8'd0 : 8'd36)) begin errors++; $display("FAIL wrap%0d_c[%0d][%0d]: got %0d want %0d", p, r, c, cap[r][c], (p == 0) ? 0 : 36); end
                end
        end
    endtask

    task automatic test_handshake();
        int n; bit gd, rs, rb, bd;
        set_identity_a();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) mat_b[r][c] = N'(10*r + c);
        load_tiles(1, 1);
        run(1, n, gd, rs, rb, bd);
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL hs_ready_with_start: got %b want 0", rs); end
        checks++; if (rb !== 1'b0) begin errors++; $display("FAIL hs_ready_while_busy: got %b want 0", rb); end
        checks++; if (!gd || n != RUN_LEN) begin errors++; $display("FAIL hs_run_len: got %0d done=%b want %0d", n, gd, RUN_LEN); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_no_restart: got busy=%b want 0", busy); end
        for (int p = 0; p < 2; p++) begin
            if (p == 1) run(0, n, gd, rs, rb, bd);
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    checks++; if (cap[r][c] !== N'(10*r + c)) begin errors++; $display("FAIL hs%0d_c[%0d][%0d]: got %0d want %0d", p, r, c, cap[r][c], 10*r + c); end
                end
        end
    endtask

    task automatic test_back_to_back();
        int n; bit gd, rs, rb, bd;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) mat_b[r][c] = N'((p == 0) ? 5*r + 2*c : 16*r + c + 2);
            load_tiles(0, 1);
            run(0, n, gd, rs, rb, bd);
            checks++; if (!gd || n != RUN_LEN) begin errors++; $display("FAIL b2b%0d_run_len: got %0d done=%b want %0d", p, n, gd, RUN_LEN); end
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    checks++; if (cap[r][c] !== mat_b[r][c]) begin errors++; $display("FAIL b2b%0d_c[%0d][%0d]: got %0d want %0d", p, r, c, cap[r][c], mat_b[r][c]); end
                end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_feed();
        test_identity();
        test_general();
        test_skew();
        test_wrap();
        test_handshake();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
